// File: rtl/kyber_pkg.sv
// Shared constants, coefficient type and sequencer state encoding for the
// Kyber-768 matrix-A parse controller.
package kyber_pkg;

    localparam int unsigned Q    = 3329;
    localparam int unsigned N    = 256;
    localparam int unsigned K    = 3;
    localparam int unsigned KW   = $clog2(K);
    // one extra bit so the counter can express "entry full" (N) distinctly
    localparam int unsigned IDXW = $clog2(N) + 1;

    typedef logic [11:0] coef_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_EMIT1,
        ST_EMIT2,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic logic cand_ok(input coef_t c);
        return c < coef_t'(Q);
    endfunction

endpackage

// File: rtl/parse_cand_split.sv
// Splits one 24-bit XOF word into two 12-bit rejection-sampling candidates
// and flags each candidate that lies below the modulus.
module parse_cand_split
    import kyber_pkg::*;
(
    input  logic [23:0] word,
    output coef_t       d1,
    output coef_t       d2,
    output logic        d1_ok,
    output logic        d2_ok
);

    always_comb begin
        d1    = word[11:0];
        d2    = word[23:12];
        d1_ok = cand_ok(word[11:0]);
        d2_ok = cand_ok(word[23:12]);
    end

endmodule

// File: rtl/parse_matrix_ctrl.sv
// Kyber matrix-A sequencer: walks the K*K entries, requests an XOF stream per
// entry and streams accepted coefficients. PARSE_CTRL_STATS_EN adds reject_cnt.
module parse_matrix_ctrl
    import kyber_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          transpose,
    output logic          busy,
    output logic          done,
    output logic          xof_req,
    output logic [7:0]    xof_b0,
    output logic [7:0]    xof_b1,
    input  logic          xof_valid,
    input  logic [23:0]   xof_data,
    output logic          xof_ready,
    output logic          coef_valid,
    output logic [11:0]   coef_data,
    output logic [7:0]    coef_idx,
    output logic [KW-1:0] coef_row,
    output logic [KW-1:0] coef_col,
    input  logic          coef_ready
`ifdef PARSE_CTRL_STATS_EN
    ,
    output logic [15:0]   reject_cnt
`endif
);

    state_t          state;
    state_t          state_n;
    logic            tr_q;
    logic [KW-1:0]   row_q;
    logic [KW-1:0]   col_q;
    logic [IDXW-1:0] idx_q;
    logic [23:0]     word_q;

    coef_t           d1;
    coef_t           d2;
    logic            d1_ok;
    logic            d2_ok;
    coef_t           cand;

    logic            run_start;
    logic            word_ld;
    logic            idx_inc;
    logic            entry_adv;
    logic            last_coef;
    logic            last_entry;

    parse_cand_split u_split (
        .word  (word_q),
        .d1    (d1),
        .d2    (d2),
        .d1_ok (d1_ok),
        .d2_ok (d2_ok)
    );

    assign last_coef  = (idx_q == IDXW'(N - 1));
    assign last_entry = (row_q == KW'(K - 1)) && (col_q == KW'(K - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        busy       = 1'b0;
        done       = 1'b0;
        xof_req    = 1'b0;
        xof_ready  = 1'b0;
        coef_valid = 1'b0;
        cand       = d1;
        run_start  = 1'b0;
        word_ld    = 1'b0;
        idx_inc    = 1'b0;
        entry_adv  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    run_start = 1'b1;
                    state_n   = ST_REQ;
                end
            end
            ST_REQ: begin
                busy    = 1'b1;
                xof_req = 1'b1;
                state_n = ST_FETCH;
            end
            ST_FETCH: begin
                busy      = 1'b1;
                xof_ready = 1'b1;
                if (xof_valid) begin
                    word_ld = 1'b1;
                    state_n = ST_EMIT1;
                end
            end
            ST_EMIT1: begin
                busy = 1'b1;
                cand = d1;
                if (d1_ok) begin
                    coef_valid = 1'b1;
                    if (coef_ready) begin
                        idx_inc = 1'b1;
                        // entry filled by d1: d2 is dropped unseen
                        state_n = last_coef ? ST_NEXT : ST_EMIT2;
                    end
                end else begin
                    state_n = ST_EMIT2;
                end
            end
            ST_EMIT2: begin
                busy = 1'b1;
                cand = d2;
                if (d2_ok) begin
                    coef_valid = 1'b1;
                    if (coef_ready) begin
                        idx_inc = 1'b1;
                        state_n = last_coef ? ST_NEXT : ST_FETCH;
                    end
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_NEXT: begin
                busy      = 1'b1;
                entry_adv = 1'b1;
                state_n   = last_entry ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tr_q   <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            if (run_start) begin
                tr_q  <= transpose;
                row_q <= '0;
                col_q <= '0;
                idx_q <= '0;
            end
            if (word_ld) begin
                word_q <= xof_data;
            end
            if (idx_inc) begin
                idx_q <= idx_q + 1'b1;
            end
            if (entry_adv) begin
                idx_q <= '0;
                if (col_q == KW'(K - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == KW'(K - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Payload is held at zero whenever no coefficient is being offered.
    always_comb begin
        coef_data = coef_valid ? cand : '0;
        coef_idx  = coef_valid ? idx_q[7:0] : '0;
        coef_row  = coef_valid ? row_q : '0;
        coef_col  = coef_valid ? col_q : '0;
        xof_b0    = '0;
        xof_b1    = '0;
        if (xof_req) begin
            xof_b0 = tr_q ? 8'(row_q) : 8'(col_q);
            xof_b1 = tr_q ? 8'(col_q) : 8'(row_q);
        end
    end

`ifdef PARSE_CTRL_STATS_EN
    logic rej_hit;

    // EMIT2 is never entered for a dropped d2, so it is never counted.
    assign rej_hit = ((state == ST_EMIT1) && !d1_ok) || ((state == ST_EMIT2) && !d2_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reject_cnt <= '0;
        end else if (run_start) begin
            reject_cnt <= '0;
        end else if (rej_hit && (reject_cnt != '1)) begin
            reject_cnt <= reject_cnt + 1'b1;
        end
    end
`endif

endmodule
